// File: rtl/rx_uart_pkg.sv
// rx_uart_pkg: shared definitions for the UART receiver with FIFO.
//   - rx_state_e   : deserialiser FSM state encoding
//   - PAR_*        : parity mode encodings on i_cfg_parity (3 behaves as none)
//   - MIN_DIVISOR  : smallest clocks-per-bit the bit timer supports
//   - par_enabled  : true when a parity mode actually carries a parity bit
package rx_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP1   = 3'd4,
    ST_STOP2   = 3'd5,
    ST_BRKWAIT = 3'd6
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int MIN_DIVISOR = 4;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, i_reset     : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  : write request and word
//   pop              : consumer ready; a pop happens when rd_valid && pop
//   rd_valid         : head word is present on rd_data
//   rd_data          : head word (forced to 0 while empty)
//   count            : current occupancy, 0..DEPTH
//   drop             : one-cycle pulse, a push was refused because the FIFO was full
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             pop_en;
  logic             push_en;

  assign full     = (cnt == CW'(DEPTH));
  assign rd_valid = (cnt != '0);
  assign pop_en   = rd_valid && pop;
  assign push_en  = push && (!full || pop_en);
  assign drop     = push && full && !pop_en;
  assign count    = cnt;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage is not reset; the read port is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rx_uart_fifo.sv
// rx_uart_fifo: asynchronous serial receiver feeding a FWFT receive FIFO.
//   clk, i_reset                 : clock, synchronous active-high reset
//   uart_txd_in                  : asynchronous serial line, idle high
//   i_cfg_divisor                : clocks per bit (values below 4 act as 4)
//   i_cfg_parity                 : 0 none, 1 even, 2 odd, 3 none
//   i_cfg_stop2                  : check a second stop bit
//   out_valid/out_ready          : receive stream handshake (see below)
//   out_data, out_perr, out_ferr, out_break : head word and its per-word flags
//   o_overrun, i_clr_overrun     : sticky dropped-frame flag and its clear
//   o_fifo_count                 : FIFO occupancy
//   dbg_state                    : current deserialiser state (rx_state_e code)
//
// Handshake: out_valid is high whenever the FIFO head holds a word; the word and
// its flags stay stable until the cycle in which out_valid && out_ready, at
// whose rising edge the word is consumed. out_ready may be high without
// out_valid; nothing happens then.
//
// Configuration is captured when a start edge is seen, so it may change freely
// while a frame is in flight.
module rx_uart_fifo
  import rx_uart_pkg::*;
#(
  parameter int TIMER_BITS = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          uart_txd_in,
  input  logic [TIMER_BITS-1:0]         i_cfg_divisor,
  input  logic [1:0]                    i_cfg_parity,
  input  logic                          i_cfg_stop2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_perr,
  output logic                          out_ferr,
  output logic                          out_break,
  output logic                          o_overrun,
  input  logic                          i_clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int         WORD_W   = DATA_BITS + 3;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Line synchroniser and start-edge detection
  // ---------------------------------------------------------------------------
  logic       sync1;
  logic       sync2;
  logic       ck;
  logic       prev_ck;
  logic [1:0] fill_cnt;
  logic       armed;
  logic       start_det;

  // The flops come out of reset at 1, so for three cycles ck shows the reset
  // value rather than the line. fill_cnt waits for the real line to reach ck,
  // and armed only rises once that real line has been seen high; a line held
  // low through reset therefore cannot fake a start edge.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      ck       <= 1'b1;
      prev_ck  <= 1'b1;
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      sync1   <= uart_txd_in;
      sync2   <= sync1;
      ck      <= sync2;
      prev_ck <= ck;
      if (fill_cnt != 2'd3) begin
        fill_cnt <= fill_cnt + 2'd1;
      end else if (ck) begin
        armed <= 1'b1;
      end
    end
  end

  assign start_det = armed && prev_ck && !ck;

  // ---------------------------------------------------------------------------
  // Deserialiser FSM
  // ---------------------------------------------------------------------------
  rx_state_e               state;
  logic [TIMER_BITS-1:0]   timer;
  logic [TIMER_BITS-1:0]   div_l;
  logic [TIMER_BITS-1:0]   div_eff;
  logic                    par_en_l;
  logic                    par_odd_l;
  logic                    stop2_l;
  logic [3:0]              bit_cnt;
  logic [DATA_BITS-1:0]    shreg;
  logic                    perr_r;
  logic                    ferr_r;
  logic                    all_zero;
  logic                    push_q;
  logic                    sample;

  assign div_eff = (i_cfg_divisor < TIMER_BITS'(MIN_DIVISOR)) ?
                   TIMER_BITS'(MIN_DIVISOR) : i_cfg_divisor;
  // Every sample point is the cycle the bit timer has counted down to zero.
  assign sample  = (timer == '0);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      div_l     <= TIMER_BITS'(MIN_DIVISOR);
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      all_zero  <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state     <= ST_START;
            // Half a bit time lands the first sample mid start bit.
            timer     <= (div_eff >> 1) - TIMER_BITS'(1);
            div_l     <= div_eff;
            par_en_l  <= par_enabled(i_cfg_parity);
            par_odd_l <= (i_cfg_parity == PAR_ODD);
            stop2_l   <= i_cfg_stop2;
            bit_cnt   <= '0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            all_zero  <= 1'b1;
          end
        end

        ST_START: begin
          if (sample) begin
            if (ck) begin
              state <= ST_IDLE;  // start bit did not hold: glitch
            end else begin
              state <= ST_DATA;
              timer <= div_l - TIMER_BITS'(1);
            end
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end

        ST_DATA: begin
          if (sample) begin
            shreg    <= {ck, shreg[DATA_BITS-1:1]};  // LSB arrives first
            all_zero <= all_zero & ~ck;
            timer    <= div_l - TIMER_BITS'(1);
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= par_en_l ? ST_PARITY : ST_STOP1;
            end
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end

        ST_PARITY: begin
          if (sample) begin
            perr_r   <= ((^shreg) ^ ck) != par_odd_l;
            all_zero <= all_zero & ~ck;
            timer    <= div_l - TIMER_BITS'(1);
            state    <= ST_STOP1;
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end

        ST_STOP1: begin
          if (sample) begin
            if (!ck) begin
              ferr_r <= 1'b1;
            end
            all_zero <= all_zero & ~ck;
            if (stop2_l) begin
              timer <= div_l - TIMER_BITS'(1);
              state <= ST_STOP2;
            end else begin
              push_q <= 1'b1;
              state  <= (all_zero && !ck) ? ST_BRKWAIT : ST_IDLE;
            end
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end

        ST_STOP2: begin
          if (sample) begin
            if (!ck) begin
              ferr_r <= 1'b1;
            end
            push_q <= 1'b1;
            // all_zero already covers STOP1; the second stop bit does not count.
            state  <= all_zero ? ST_BRKWAIT : ST_IDLE;
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end

        ST_BRKWAIT: begin
          // A break must end (line high) before another frame can start.
          if (ck) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Receive FIFO and overrun flag
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] head_word;
  logic              fifo_drop;

  // all_zero at push time is the break indication; a break always has STOP1
  // low, so ferr_r is already set alongside it.
  assign push_word = {shreg, perr_r, ferr_r, all_zero};

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_reset   (i_reset),
    .push      (push_q),
    .push_data (push_word),
    .pop       (out_ready),
    .rd_valid  (out_valid),
    .rd_data   (head_word),
    .count     (o_fifo_count),
    .drop      (fifo_drop)
  );

  assign out_data  = head_word[WORD_W-1:3];
  assign out_perr  = head_word[2];
  assign out_ferr  = head_word[1];
  assign out_break = head_word[0];

  // A drop in the same cycle as a clear wins, so no overrun is ever lost.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_overrun <= 1'b0;
    end else if (fifo_drop) begin
      o_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_uart_fifo.sv
`timescale 1ns/1ps
module tb_rx_uart_fifo;
  import rx_uart_pkg::*;

  localparam int TIMER_BITS = 16;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int WW         = DATA_BITS + 3;

  // ---------------------------------------------------------------- clock/reset
  logic                  clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic                  uart_txd_in = 1'b1;
  logic [TIMER_BITS-1:0] i_cfg_divisor = 16'd16;
  logic [1:0]            i_cfg_parity = 2'd0;
  logic                  i_cfg_stop2 = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [DATA_BITS-1:0]  out_data;
  logic                  out_perr;
  logic                  out_ferr;
  logic                  out_break;
  logic                  o_overrun;
  logic                  i_clr_overrun = 1'b0;
  logic [CW-1:0]         o_fifo_count;
  logic [2:0]            dbg_state;

  always #5 clk = ~clk;

  rx_uart_fifo #(
    .TIMER_BITS (TIMER_BITS),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .uart_txd_in   (uart_txd_in),
    .i_cfg_divisor (i_cfg_divisor),
    .i_cfg_parity  (i_cfg_parity),
    .i_cfg_stop2   (i_cfg_stop2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_perr      (out_perr),
    .out_ferr      (out_ferr),
    .out_break     (out_break),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun),
    .o_fifo_count  (o_fifo_count),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [WW-1:0] exp_q[$];
  bit            exp_overrun = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;
  logic [WW-1:0] mon_got;
  logic [WW-1:0] mon_exp;

  // Reference word {data, perr, ferr, break} from the frame as transmitted.
  function automatic logic [WW-1:0] model_word(input logic [7:0] d, input logic [1:0] pm,
                                               input logic pbit, input logic s2en,
                                               input logic st1, input logic st2);
    int   ones;
    logic pen, perr, ferr, brk;
    ones = $countones(d) + int'(pbit);
    pen  = (pm == 2'd1) || (pm == 2'd2);
    perr = 1'b0;
    if (pm == 2'd1) perr = (ones % 2) != 0;
    else if (pm == 2'd2) perr = (ones % 2) != 1;
    brk  = (d == 8'h00) && (!pen || !pbit) && !st1;
    ferr = !st1 || (s2en && !st2) || brk;
    return {d, perr, ferr, brk};
  endfunction

  // A word that finds the FIFO full (nobody consuming) is lost and flags overrun.
  task automatic model_push(input logic [WW-1:0] w);
    if (exp_q.size() >= FIFO_DEPTH) exp_overrun = 1'b1;
    else exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!i_reset && out_valid && out_ready) begin
      mon_got = {out_data, out_perr, out_ferr, out_break};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got word %h, expected no word", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL sb_word: got {data,perr,ferr,brk}=%h expected %h", mon_got, mon_exp);
        else n_pass++;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_bit(input logic v, input int period);
    uart_txd_in = v;
    repeat (period) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic s2en, input logic st1, input logic st2,
                            input int div, input bit scramble);
    int period;
    period = (div < 4) ? 4 : div;
    i_cfg_divisor = 16'(div);
    i_cfg_parity  = pm;
    i_cfg_stop2   = s2en;
    model_push(model_word(d, pm, pbit, s2en, st1, st2));
    drive_bit(1'b0, period);
    if (scramble) begin
      i_cfg_divisor = 16'($urandom_range(0, 40));
      i_cfg_parity  = 2'($urandom_range(0, 3));
      i_cfg_stop2   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], period);
    if (pm == 2'd1 || pm == 2'd2) drive_bit(pbit, period);
    drive_bit(st1, period);
    if (s2en) drive_bit(st2, period);
    drive_bit(1'b1, 2 * period);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    bit left_idle;
    i_reset = 1'b1;
    uart_txd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (o_fifo_count !== '0) $display("FAIL reset_count: got %0d expected 0", o_fifo_count); else n_pass++;
    n_checks++; if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", o_overrun); else n_pass++;
    n_checks++;
    if ({out_data, out_perr, out_ferr, out_break} !== '0)
      $display("FAIL reset_data: got %h expected 0", {out_data, out_perr, out_ferr, out_break});
    else n_pass++;
    n_checks++; if (dbg_state !== 3'(ST_IDLE)) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    // Line held low across reset release must not look like a start bit.
    uart_txd_in = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    left_idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state !== 3'(ST_IDLE)) left_idle = 1'b1;
    end
    n_checks++; if (left_idle !== 1'b0) $display("FAIL reset_low_line: got left_idle=%b expected 0", left_idle); else n_pass++;
    uart_txd_in = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    out_ready = 1'b0;
    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL basic_data: got %h expected a5", out_data); else n_pass++;
    n_checks++;
    if ({out_perr, out_ferr, out_break} !== 3'b000)
      $display("FAIL basic_flags: got %b expected 000", {out_perr, out_ferr, out_break});
    else n_pass++;
    n_checks++; if (o_fifo_count !== CW'(1)) $display("FAIL basic_count: got %0d expected 1", o_fifo_count); else n_pass++;
    out_ready = 1'b1;
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL basic_drain: got timeout expected drained"); else n_pass++;
  endtask

  task automatic test_parity();
    bit ok;
    out_ready = 1'b0;
    send_frame(8'h3C, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    n_checks++; if (out_perr !== 1'b1) $display("FAIL parity_even_perr: got %b expected 1", out_perr); else n_pass++;
    out_ready = 1'b1;
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL parity_even_drain: got timeout expected drained"); else n_pass++;
    out_ready = 1'b0;
    send_frame(8'h3C, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    n_checks++; if (out_perr !== 1'b0) $display("FAIL parity_odd_perr: got %b expected 0", out_perr); else n_pass++;
    out_ready = 1'b1;
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL parity_odd_drain: got timeout expected drained"); else n_pass++;
  endtask

  task automatic test_glitch();
    bit saw_start;
    i_cfg_divisor = 16'd16;
    i_cfg_parity  = 2'd0;
    i_cfg_stop2   = 1'b0;
    saw_start = 1'b0;
    uart_txd_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state === 3'(ST_START)) saw_start = 1'b1;
    end
    uart_txd_in = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state === 3'(ST_START)) saw_start = 1'b1;
    end
    n_checks++; if (saw_start !== 1'b1) $display("FAIL glitch_seen: got %b expected 1", saw_start); else n_pass++;
    n_checks++; if (dbg_state !== 3'(ST_IDLE)) $display("FAIL glitch_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (o_fifo_count !== '0) $display("FAIL glitch_count: got %0d expected 0", o_fifo_count); else n_pass++;
  endtask

  task automatic test_break();
    bit ok;
    i_cfg_divisor = 16'd16;
    i_cfg_parity  = 2'd0;
    i_cfg_stop2   = 1'b0;
    model_push(model_word(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_bit(1'b0, 12 * 16);
    drive_bit(1'b1, 4 * 16);
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL break_drain: got timeout expected drained"); else n_pass++;
    repeat (64) @(posedge clk);
    #1;
    n_checks++; if (o_fifo_count !== '0) $display("FAIL break_second_word: got count %0d expected 0", o_fifo_count); else n_pass++;
    n_checks++; if (dbg_state !== 3'(ST_IDLE)) $display("FAIL break_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] d;
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      d = 8'($urandom_range(1, 255));
      send_frame(d, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, 16, 1'b0);
    end
    n_checks++; if (o_fifo_count !== CW'(exp_q.size())) $display("FAIL overrun_count: got %0d expected %0d", o_fifo_count, exp_q.size()); else n_pass++;
    n_checks++; if (o_overrun !== exp_overrun) $display("FAIL overrun_flag: got %b expected %b", o_overrun, exp_overrun); else n_pass++;
    n_checks++; if (out_data !== exp_q[0][WW-1:3]) $display("FAIL overrun_head: got %h expected %h", out_data, exp_q[0][WW-1:3]); else n_pass++;
    i_clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    i_clr_overrun = 1'b0;
    exp_overrun = 1'b0;
    n_checks++; if (o_overrun !== exp_overrun) $display("FAIL overrun_clear: got %b expected %b", o_overrun, exp_overrun); else n_pass++;
    out_ready = 1'b1;
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL overrun_drain: got timeout expected drained"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    i_cfg_divisor = 16'd16;
    i_cfg_parity  = 2'd0;
    i_cfg_stop2   = 1'b0;
    // Partial frame: start bit and three data bits, then reset inside DATA.
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== 3'(ST_DATA)) $display("FAIL mid_in_data: got %0d expected %0d", dbg_state, ST_DATA); else n_pass++;
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    uart_txd_in = 1'b1;
    n_checks++; if (dbg_state !== 3'(ST_IDLE)) $display("FAIL mid_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    repeat (32) @(posedge clk);
    #1;
    n_checks++; if (o_fifo_count !== '0) $display("FAIL mid_no_push: got %0d expected 0", o_fifo_count); else n_pass++;
    send_frame(8'h81, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0);
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mid_drain: got timeout expected drained"); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d;
    int div;
    for (int f = 0; f < 16; f++) begin
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      div = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
      send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), div, 1'b1);
    end
    wait_drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL random_drain: got timeout expected drained"); else n_pass++;
    n_checks++; if (o_overrun !== exp_overrun) $display("FAIL random_overrun: got %b expected %b", o_overrun, exp_overrun); else n_pass++;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    n_checks++;
    $display("FAIL watchdog: got no completion within 200000 cycles, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rx_uart_fifo.md
RX_UART_FIFO -- requirements
Module: rx_uart_fifo

Interface
REQ-001 Parameter TIMER_BITS, default 16, width of the baud divisor and bit timer.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, minimum 2.
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port i_reset  input  1  reset, synchronous, active-high.
REQ-006 Port uart_txd_in  input  1  asynchronous serial line, idle high.
REQ-007 Port i_cfg_divisor  input  TIMER_BITS  clocks per bit; values below 4 are treated as 4.
REQ-008 Port i_cfg_parity  input  2  parity mode: 0 none, 1 even, 2 odd, 3 treated as none.
REQ-009 Port i_cfg_stop2  input  1  when 1, two stop bits are checked.
REQ-010 Port out_valid  output  1  FIFO head holds a word.
REQ-011 Port out_ready  input  1  consumer accepts the head word when out_valid is also 1.
REQ-012 Port out_data  output  DATA_BITS  head word data, LSB received first.
REQ-013 Port out_perr / out_ferr / out_break  output  1 each  per-word parity error, framing error and break flags, stored with the data.
REQ-014 Port o_overrun  output  1  sticky; a completed frame was dropped because the FIFO was full.
REQ-015 Port i_clr_overrun  input  1  clears o_overrun.
REQ-016 Port o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 uart_txd_in shall pass through a 3-flop synchroniser; all decoding shall use the third flop output (ck).
REQ-018 The state machine shall have states IDLE, START, DATA, PARITY, STOP1, STOP2 and BRKWAIT.
REQ-019 IDLE->START on a falling edge of ck (previous ck 1, current ck 0); divisor, parity mode and stop2 shall be latched at this point, and later config changes shall not affect the frame.
REQ-020 In START, the bit timer shall load (div>>1)-1 and count down; at 0, ck=1 shall return to IDLE (glitch, nothing pushed), otherwise go to DATA with the timer reloaded to div-1.
REQ-021 Each subsequent sample point shall be the cycle the timer reaches 0, after which the timer reloads div-1.
REQ-022 DATA shall take DATA_BITS samples LSB-first, then go to PARITY if parity is enabled, else to STOP1.
REQ-023 PARITY shall set perr if the XOR of the data bits and the parity bit is not 0 (even mode) or not 1 (odd mode); perr shall be 0 when parity is none.
REQ-024 STOP1, then STOP2 if stop2 is latched, shall set ferr if any stop sample is 0.
REQ-025 break shall be 1 when all data samples, the parity sample (if enabled) and STOP1 are 0; when break is 1, ferr shall also be 1.
REQ-026 One cycle after the last stop sample, {data, perr, ferr, break} shall be pushed into the FIFO.
REQ-027 After the push, the FSM shall enter BRKWAIT if break is 1, else IDLE; BRKWAIT->IDLE when ck=1, with no new start detected during BRKWAIT.
REQ-028 The FIFO shall be first-word-fall-through; a push into an empty FIFO shall assert out_valid the following cycle.
REQ-029 A pop shall occur when out_valid and out_ready are both 1.
REQ-030 A push shall be accepted when count<FIFO_DEPTH, or when full and a pop occurs in the same cycle.
REQ-031 A push into a full FIFO without a pop shall drop the word and set o_overrun.
REQ-032 Simultaneous push and pop shall leave the count unchanged.
REQ-033 Pointers shall wrap modulo FIFO_DEPTH.
REQ-034 i_clr_overrun shall clear o_overrun; a new overrun in the same cycle shall take precedence and set it.
REQ-035 Latency from the line's stop-bit sample instant to out_valid shall be 3 sync cycles + 1 push cycle + 1 cycle.

Reset
REQ-036 On i_reset, state shall be IDLE, the FIFO empty, out_valid=0, o_fifo_count=0, o_overrun=0, and out_data and all flags 0.
REQ-037 On i_reset, the synchroniser flops and previous-ck register shall be set to 1, so a line held low after reset produces no start until it has been seen high.
REQ-038 A reset mid-frame shall discard the partial frame without pushing.

Structure
REQ-039 Package rx_uart_pkg shall hold the state enum, the parity-mode encodings (PAR_NONE/EVEN/ODD) and MIN_DIVISOR=4.
REQ-040 The FIFO shall be the sub-module sync_fifo (parametrised WIDTH, DEPTH; FWFT; count output); the deserialiser FSM stays in rx_uart_fifo.

Verification (div=16, DATA_BITS=8, FIFO_DEPTH=4)
REQ-041 Send 0xA5, parity none, 1 stop -> one word out_data=0xA5 with perr=ferr=break=0.
REQ-042 Send 0x3C with even parity and parity bit 1 -> perr=1; repeat in odd mode -> perr=0.
REQ-043 Low pulse of 5 clocks on the idle line -> no push, FSM back in IDLE, count stays 0.
REQ-044 Hold the line low for 12 bit times, then release -> exactly one word: data=0x00, ferr=1, break=1; no second word.
REQ-045 Send 5 frames with out_ready=0 -> count=4, o_overrun=1, head=first frame; i_clr_overrun clears it; draining yields frames 1-4 in order.
REQ-046 Assert i_reset during DATA, then send 0x81 with stop2=1 and the second stop bit low -> only 0x81 is received, with ferr=1.
